// File: rtl/sdram_write_queue_if.sv
// Signal bundle between sdram_write_queue, its cache/CPU client, the SDRAM bus arbiter
// and the burst-write sequencer. The queue uses the slave modport; the client side uses master.
interface sdram_write_queue_if #(
  parameter int DATA_BLOCK_SIZE = 128,
  parameter int DEPTH           = 4,
  parameter int ADDR_WIDTH      = 26
);
  // Upstream valid/ready: a request transfers on every iclk edge where ivalid && oready.
  // ivalid may rise without waiting for oready; iaddr/idata must hold while ivalid waits.
  logic                       ivalid;
  logic                       oready;
  logic [ADDR_WIDTH-1:0]      iaddr;
  logic [DATA_BLOCK_SIZE-1:0] idata;
  logic                       obus_req;
  logic                       igrant;
  logic                       oenb;
  logic                       oreq;
  logic                       ifin;
  logic [12:0]                orow;
  logic [9:0]                 ocolumn;
  logic [1:0]                 obank;
  logic [DATA_BLOCK_SIZE-1:0] odata;
  logic [$clog2(DEPTH):0]     ocount;
  logic                       oerr;
  logic [2:0]                 odbg_state;

  modport slave (
    input  ivalid, iaddr, idata, igrant, ifin,
    output oready, obus_req, oenb, oreq, orow, ocolumn, obank, odata, ocount, oerr, odbg_state
  );

  modport master (
    output ivalid, iaddr, idata, igrant, ifin,
    input  oready, obus_req, oenb, oreq, orow, ocolumn, obank, odata, ocount, oerr, odbg_state
  );
endinterface

// File: rtl/sdram_write_queue.sv
// Block-write FIFO in front of the SDRAM burst-write sequencer: buffers aligned requests,
// wins the SDRAM bus from the arbiter, starts one burst per entry and pops on completion.
module sdram_write_queue #(
  parameter int DATA_BLOCK_SIZE = 128,
  parameter int DEPTH           = 4,
  parameter int ADDR_WIDTH      = 26
) (
  input  logic              iclk,
  input  logic              ireset,
  sdram_write_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_BUS_WAIT = 3'd1,
    S_ISSUE    = 3'd2,
    S_WAIT_FIN = 3'd3,
    S_RELEASE  = 3'd4
  } state_t;

  // Entries keep the 16-bit word address; byte bit 0 only matters for the alignment check.
  logic [ADDR_WIDTH-2:0]      r_word_mem [DEPTH];
  logic [DATA_BLOCK_SIZE-1:0] r_data_mem [DEPTH];
  logic [PW-1:0]              r_wr_ptr;
  logic [PW-1:0]              r_rd_ptr;
  logic [CW-1:0]              r_count;
  logic                       r_err;

  state_t                     r_state;
  logic                       r_bus_req;
  logic                       r_enb;
  logic                       r_req;
  logic [12:0]                r_row;
  logic [9:0]                 r_col;
  logic [1:0]                 r_bank;
  logic [DATA_BLOCK_SIZE-1:0] r_odata;

  logic                       w_not_full;
  logic                       w_accept;
  logic                       w_aligned;
  logic                       w_push;
  logic                       w_pop;
  logic [ADDR_WIDTH-2:0]      w_head_word;

  assign w_not_full  = (r_count != FULL);
  assign w_accept    = bus.ivalid && w_not_full;
  assign w_aligned   = (bus.iaddr[3:0] == 4'h0);
  assign w_push      = w_accept && w_aligned;
  assign w_pop       = (r_state == S_WAIT_FIN) && bus.ifin;
  assign w_head_word = r_word_mem[r_rd_ptr];

  always_ff @(posedge iclk) begin
    if (w_push) begin
      r_word_mem[r_wr_ptr] <= bus.iaddr[ADDR_WIDTH-1:1];
      r_data_mem[r_wr_ptr] <= bus.idata;
    end
  end

  // Pointers are exactly log2(DEPTH) bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge iclk) begin
    if (ireset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_accept && !w_aligned) r_err <= 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Row/bank/column/data are captured only on the IDLE exit and then held for the whole
  // burst, because the sequencer samples row and column in different cycles.
  always_ff @(posedge iclk) begin
    if (ireset) begin
      r_state   <= S_IDLE;
      r_bus_req <= 1'b0;
      r_enb     <= 1'b0;
      r_req     <= 1'b0;
      r_row     <= '0;
      r_col     <= '0;
      r_bank    <= '0;
      r_odata   <= '0;
    end else begin
      r_req <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_count != '0) begin
            r_state   <= S_BUS_WAIT;
            r_bus_req <= 1'b1;
            r_row     <= w_head_word[24:12];
            r_bank    <= w_head_word[11:10];
            r_col     <= w_head_word[9:0];
            r_odata   <= r_data_mem[r_rd_ptr];
          end
        end
        S_BUS_WAIT: begin
          if (bus.igrant) begin
            r_state <= S_ISSUE;
            r_enb   <= 1'b1;
            r_req   <= 1'b1;
          end
        end
        S_ISSUE: r_state <= S_WAIT_FIN;
        S_WAIT_FIN: begin
          if (bus.ifin) begin
            r_state   <= S_RELEASE;
            r_enb     <= 1'b0;
            r_bus_req <= 1'b0;
          end
        end
        S_RELEASE: r_state <= S_IDLE;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.oready     = w_not_full;
  assign bus.obus_req   = r_bus_req;
  assign bus.oenb       = r_enb;
  assign bus.oreq       = r_req;
  assign bus.orow       = r_row;
  assign bus.ocolumn    = r_col;
  assign bus.obank      = r_bank;
  assign bus.odata      = r_odata;
  assign bus.ocount     = r_count;
  assign bus.oerr       = r_err;
  assign bus.odbg_state = r_state;
endmodule
